gpio_sequence_monitor: RTL and testbench

Synthesizable, parametrised checker that watches a user GPIO bus for an ordered sequence of expected patterns. It provides pass, fail and timeout status in hardware, so a wrapper or the management SoC can self-check pin activity without a simulation bench. It sits inside the user project wrapper on the Wishbone clock domain. It generalises the fixed 8-bit, fixed-sequence I/O check with:
- configurable width and depth;
- per-step masks;
- a glitch filter;
- a strict-order mode;
- a per-step timeout.

---
 rtl/gpio_sequence_monitor.sv | 165 ++++++++++++++++
 tb/tb_gpio_sequence_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_sequence_monitor.sv
// Watches a GPIO bus for an ordered table of masked patterns and reports sticky
// pass / fail / timeout status. Inputs are synchronised and glitch-filtered first.
module gpio_sequence_monitor #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int STABLE_CYC = 2,
   parameter int TMO_W      = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [WIDTH-1:0]          io_in,
   input  logic                      tbl_we,
   input  logic [$clog2(DEPTH)-1:0]  tbl_addr,
   input  logic [WIDTH-1:0]          tbl_exp,
   input  logic [WIDTH-1:0]          tbl_mask,
   input  logic [$clog2(DEPTH):0]    seq_len,
   input  logic [TMO_W-1:0]          timeout_lim,
   input  logic                      strict,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      pass,
   output logic                      fail,
   output logic                      tmo,
   output logic [$clog2(DEPTH):0]    step,
   output logic [WIDTH-1:0]          obs
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYC - 1);
   localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  sync_p0, sync_p1, obs_q;
   logic [CW-1:0]     stab_cnt;
   logic              settle;
   logic [WIDTH-1:0]  exp_mem  [DEPTH];
   logic [WIDTH-1:0]  mask_mem [DEPTH];
   logic [AW:0]       step_q, len_q, step_nxt;
   logic [TMO_W-1:0]  timer_q, lim_q, timer_inc;
   logic              strict_q, tmo_q;
   logic              match, last_hit, strict_miss, timer_hit;

   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      return (&v) ? v : v + TMO_W'(1);
   endfunction

   function automatic logic [AW:0] clamp_len(input logic [AW:0] v);
      return (v > LEN_MAX) ? LEN_MAX : v;
   endfunction

   // Stage p0/p1: two-flop synchroniser, then the settle filter feeding obs
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         stab_cnt <= '0;
         obs_q    <= '0;
         settle   <= 1'b0;
      end else begin
         sync_p0 <= io_in;
         sync_p1 <= sync_p0;
         if (sync_p0 != sync_p1)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_LAST)
            stab_cnt <= stab_cnt + CW'(1);
         settle <= 1'b0;
         if (stab_cnt == STAB_LAST) begin
            obs_q  <= sync_p1;
            settle <= (sync_p1 != obs_q);
         end
      end
   end

   // Table survives reset; it is only writable while no check is running
   always_ff @(posedge wb_clk_i) begin
      if (tbl_we && state_q != RUN) begin
         exp_mem[tbl_addr]  <= tbl_exp;
         mask_mem[tbl_addr] <= tbl_mask;
      end
   end

   always_comb begin
      match       = (((obs_q ^ exp_mem[step_q[AW-1:0]]) & mask_mem[step_q[AW-1:0]]) == '0);
      step_nxt    = step_q + (AW+1)'(1);
      last_hit    = (step_nxt == len_q);
      timer_inc   = sat_inc(timer_q);
      timer_hit   = (lim_q != '0) && (timer_inc == lim_q);
      strict_miss = strict_q && settle;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Match wins over strict mismatch and timeout in the same cycle
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            RUN: begin
               if (match) begin
                  if (last_hit)
                     state_d = PASS;
               end else if (strict_miss || timer_hit) begin
                  state_d = FAIL;
               end
            end
            default: begin
               if (start)
                  state_d = (clamp_len(seq_len) == '0) ? PASS : RUN;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         step_q   <= '0;
         timer_q  <= '0;
         tmo_q    <= 1'b0;
         len_q    <= '0;
         lim_q    <= '0;
         strict_q <= 1'b0;
      end else if (abort) begin
         step_q  <= '0;
         timer_q <= '0;
         tmo_q   <= 1'b0;
      end else if (state_q != RUN && start) begin
         step_q   <= '0;
         timer_q  <= '0;
         tmo_q    <= 1'b0;
         len_q    <= clamp_len(seq_len);
         lim_q    <= timeout_lim;
         strict_q <= strict;
      end else if (state_q == RUN) begin
         if (match) begin
            step_q  <= step_nxt;
            timer_q <= '0;
         end else begin
            timer_q <= timer_inc;
            if (timer_hit)
               tmo_q <= 1'b1;
         end
      end
   end

   always_comb begin
      busy = (state_q == RUN);
      pass = (state_q == PASS);
      fail = (state_q == FAIL);
      tmo  = tmo_q;
      step = step_q;
      obs  = obs_q;
   end

endmodule

// File: tb/tb_gpio_sequence_monitor.sv
// Bench for gpio_sequence_monitor: table-driven sequences checked through a
// scoreboard queue, plus hand-written timeout, glitch, mask and reset scenarios.
module tb_gpio_sequence_monitor;

   logic        clk, rst;
   logic [7:0]  io_in, tbl_exp, tbl_mask, obs;
   logic        tbl_we, strict, start, abort;
   logic [3:0]  tbl_addr;
   logic [4:0]  seq_len, step;
   logic [15:0] timeout_lim;
   logic        busy, pass, fail, tmo;

   int n_tests, n_fail;

   typedef struct {
      logic [7:0] io;
      int         hold;
      int         e_step;
      bit         e_pass;
      bit         e_fail;
      bit         e_busy;
   } vec_t;

   typedef struct {
      int         step;
      bit         pass;
      bit         fail;
      bit         busy;
      logic [7:0] obs;
      string      tag;
   } exp_t;

   vec_t       vecs[$];
   exp_t       sb[$];
   logic [7:0] seq_vals [12];

   gpio_sequence_monitor #(
      .WIDTH(8), .DEPTH(16), .STABLE_CYC(2), .TMO_W(16)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io_in),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_exp(tbl_exp), .tbl_mask(tbl_mask),
      .seq_len(seq_len), .timeout_lim(timeout_lim), .strict(strict),
      .start(start), .abort(abort),
      .busy(busy), .pass(pass), .fail(fail), .tmo(tmo), .step(step), .obs(obs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary, n_tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic add_vec(input logic [7:0] io, input int hold, input int st,
                          input bit p, input bit f, input bit b);
      vec_t v;
      v.io = io; v.hold = hold; v.e_step = st;
      v.e_pass = p; v.e_fail = f; v.e_busy = b;
      vecs.push_back(v);
   endtask

   task automatic tbl_wr(input int addr, input logic [7:0] e, input logic [7:0] m);
      tbl_addr = 4'(addr);
      tbl_exp  = e;
      tbl_mask = m;
      tbl_we   = 1'b1;
      tick();
      tbl_we   = 1'b0;
   endtask

   task automatic do_start(input int len, input int lim, input bit st);
      seq_len     = 5'(len);
      timeout_lim = 16'(lim);
      strict      = st;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic settle_io(input logic [7:0] v);
      io_in = v;
      repeat (8) tick();
   endtask

   task automatic wait_step(input int n, input int budget);
      int c;
      c = 0;
      while (int'(step) != n && c < budget) begin
         tick();
         c++;
      end
      check($sformatf("wait_step%0d", n), int'(step), n);
   endtask

   task automatic apply_vecs(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) begin
         exp_t e;
         io_in  = vecs[i].io;
         e.step = vecs[i].e_step;
         e.pass = vecs[i].e_pass;
         e.fail = vecs[i].e_fail;
         e.busy = vecs[i].e_busy;
         e.obs  = vecs[i].io;
         e.tag  = $sformatf("%s[%0d]", tag, i);
         sb.push_back(e);
         repeat (vecs[i].hold) tick();
         e = sb.pop_front();
         check({e.tag, ".step"}, int'(step), e.step);
         check({e.tag, ".pass"}, int'(pass), int'(e.pass));
         check({e.tag, ".fail"}, int'(fail), int'(e.fail));
         check({e.tag, ".busy"}, int'(busy), int'(e.busy));
         check({e.tag, ".obs"},  int'(obs),  int'(e.obs));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".pass"}, int'(pass), 0);
      check({tag, ".fail"}, int'(fail), 0);
      check({tag, ".tmo"},  int'(tmo),  0);
      check({tag, ".step"}, int'(step), 0);
      check({tag, ".obs"},  int'(obs),  0);
   endtask

   initial begin
      int fail_at, seen5;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; io_in = '0; tbl_we = 1'b0; tbl_addr = '0; tbl_exp = '0; tbl_mask = '0;
      seq_len = '0; timeout_lim = '0; strict = 1'b0; start = 1'b0; abort = 1'b0;

      for (int i = 0; i < 10; i++) seq_vals[i] = 8'(i + 1);
      seq_vals[10] = 8'hFF;
      seq_vals[11] = 8'h00;

      // 0..11: full sequence; 12..14: strict run; 15..17: relaxed run
      for (int i = 0; i < 11; i++) add_vec(seq_vals[i], 10, i + 1, 0, 0, 1);
      add_vec(seq_vals[11], 10, 12, 1, 0, 0);
      add_vec(8'h01, 10, 1, 0, 0, 1);
      add_vec(8'h02, 10, 2, 0, 0, 1);
      add_vec(8'h07, 10, 2, 0, 1, 0);
      add_vec(8'h01, 10, 1, 0, 0, 1);
      add_vec(8'h02, 10, 2, 0, 0, 1);
      add_vec(8'h07, 10, 2, 0, 0, 1);

      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) tbl_wr(i, seq_vals[i], 8'hFF);
      settle_io(8'h00);

      do_start(12, 0, 0);
      check("start.busy", int'(busy), 1);
      apply_vecs(0, 11, "seq");

      do_start(12, 0, 1);
      apply_vecs(12, 14, "strict");
      check("strict.tmo", int'(tmo), 0);

      do_start(12, 0, 0);
      apply_vecs(15, 17, "relaxed");

      // Timeout: stall on step 2 with a value that never matches
      do_abort();
      check("abort.busy", int'(busy), 0);
      check("abort.step", int'(step), 0);
      settle_io(8'h00);
      do_start(12, 50, 0);
      io_in = 8'h01;
      wait_step(1, 40);
      io_in = 8'h02;
      wait_step(2, 40);
      io_in = 8'h07;
      fail_at = -1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (fail && fail_at < 0) fail_at = c;
      end
      check("tmo.fail_cycle", fail_at, 50);
      check("tmo.tmo", int'(tmo), 1);
      check("tmo.step", int'(step), 2);
      check("tmo.busy", int'(busy), 0);

      // One-cycle glitch must never reach obs
      do_abort();
      settle_io(8'h00);
      do_start(12, 0, 0);
      io_in = 8'h01;
      repeat (10) tick();
      check("glitch.pre_step", int'(step), 1);
      io_in = 8'h05;
      tick();
      io_in = 8'h01;
      seen5 = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (obs == 8'h05) seen5++;
      end
      check("glitch.obs_seen", seen5, 0);
      check("glitch.step", int'(step), 1);
      check("glitch.obs", int'(obs), 8'h01);
      io_in = 8'h05;
      repeat (10) tick();
      check("held.obs", int'(obs), 8'h05);
      check("held.step", int'(step), 1);

      // Masked compare and zero-length sequence
      do_abort();
      tbl_wr(0, 8'h03, 8'h0F);
      settle_io(8'hA3);
      do_start(1, 0, 0);
      check("mask.busy", int'(busy), 1);
      check("mask.pass_early", int'(pass), 0);
      tick();
      check("mask.pass", int'(pass), 1);
      check("mask.step", int'(step), 1);
      check("mask.busy_done", int'(busy), 0);
      do_abort();
      check("abort.pass", int'(pass), 0);
      do_start(0, 0, 0);
      check("len0.pass", int'(pass), 1);
      check("len0.busy", int'(busy), 0);
      tbl_wr(0, 8'h01, 8'hFF);

      // Reset mid-run, table retained, write while busy ignored
      do_abort();
      settle_io(8'h00);
      do_start(12, 0, 0);
      for (int v = 1; v <= 4; v++) begin
         io_in = 8'(v);
         repeat (10) tick();
      end
      check("mid.step", int'(step), 4);
      tbl_wr(5, 8'h55, 8'hFF);
      check("busy_wr.step", int'(step), 4);
      rst = 1'b1;
      #1;
      check_reset_vals("async_rst");
      io_in = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      repeat (6) tick();
      do_start(12, 0, 0);
      apply_vecs(0, 11, "rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
